// File: rtl/vec_int_ctrl_if.sv
// Bus bundle between the interrupt controller, its sources and the sequencer.
// The slave side is the controller; the master side drives sources/handshake.
interface vec_int_if #(
    parameter int NCH = 8,
    parameter int AW  = 8,
    parameter int IDW = $clog2(NCH)
);
    logic [NCH-1:0] itr_in;
    logic           itr_en;
    logic [NCH-1:0] mask_in;
    logic           mask_we;
    logic [NCH-1:0] pend_clr;
    logic           int_ack;
    logic           iret;
    logic           i_pending;
    logic [AW-1:0]  PC_out;
    logic [IDW-1:0] int_id;
    logic           in_service;
    logic [NCH-1:0] ITR_register;
    logic [NCH-1:0] MASK_register;

    modport master (
        output itr_in, itr_en, mask_in, mask_we, pend_clr, int_ack, iret,
        input  i_pending, PC_out, int_id, in_service, ITR_register, MASK_register
    );

    modport slave (
        input  itr_in, itr_en, mask_in, mask_we, pend_clr, int_ack, iret,
        output i_pending, PC_out, int_id, in_service, ITR_register, MASK_register
    );
endinterface

// File: rtl/vec_int_ctrl.sv
// Vectored priority interrupt controller: sticky pending latches with
// per-channel edge/level detection, maskable fixed-priority arbitration and a
// request/acknowledge/return handshake that freezes the ISR vector.
module vec_int_ctrl #(
    parameter int             NCH        = 8,
    parameter int             AW         = 8,
    parameter int             IDW        = $clog2(NCH),
    parameter logic [AW-1:0]  VEC_BASE   = 8'h96,
    parameter logic [AW-1:0]  VEC_STRIDE = 8'h10,
    parameter logic [NCH-1:0] EDGE_MODE  = {NCH{1'b1}},
    parameter logic [NCH-1:0] MASK_RST   = {NCH{1'b1}}
) (
    input logic      clk,
    input logic      clr,
    vec_int_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt_s;
    logic           load_s;
    logic [NCH-1:0] pend_r;
    logic [NCH-1:0] mask_r;
    logic [NCH-1:0] itr_d_r;
    logic           primed_r;
    logic [IDW-1:0] int_id_r;
    logic [AW-1:0]  pc_r;
    logic           i_pending_r;
    logic           in_service_r;
    logic [NCH-1:0] req_s;
    logic [NCH-1:0] set_s;
    logic [NCH-1:0] clear_s;
    logic [IDW-1:0] winner_s;

    // Lowest set index of the request vector (index 0 has highest priority).
    function automatic logic [IDW-1:0] pick_winner(input logic [NCH-1:0] req);
        logic [IDW-1:0] id;
        id = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            id = req[i] ? IDW'(i) : id;
        end
        return id;
    endfunction

    // Vector address of a channel; the sum wraps modulo 2^AW.
    function automatic logic [AW-1:0] vector_of(input logic [IDW-1:0] id);
        logic [AW-1:0] v;
        v = VEC_BASE + (AW'(id) * VEC_STRIDE);
        return v;
    endfunction

    // itr_d_r is zero after reset, so edge detection is held off until the
    // first post-reset sample; a line already high across reset release is
    // therefore not taken as a new edge.
    assign set_s    = (EDGE_MODE & bus.itr_in & ~itr_d_r & {NCH{primed_r}})
                    | (~EDGE_MODE & bus.itr_in);
    assign req_s    = pend_r & mask_r;
    assign winner_s = pick_winner(req_s);

    // Pending-bit clear sources: software write-1-to-clear and acknowledge.
    always_comb begin
        clear_s = bus.pend_clr;
        if ((state_r == ST_REQ) && bus.int_ack) begin
            clear_s[int_id_r] = 1'b1;
        end else begin
            clear_s = bus.pend_clr;
        end
    end

    // Next-state decode of the request/service handshake.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.itr_en && (req_s != '0)) begin
                    state_nxt_s = ST_REQ;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.int_ack) begin
                    state_nxt_s = ST_SVC;
                end else if (!bus.itr_en) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SVC: begin
                if (bus.iret) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SVC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r      <= ST_IDLE;
            i_pending_r  <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            i_pending_r  <= (state_nxt_s == ST_REQ);
            in_service_r <= (state_nxt_s == ST_SVC);
        end
    end

    // Sticky pending latches; a set in the same cycle beats any clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend_r   <= '0;
            itr_d_r  <= '0;
            primed_r <= 1'b0;
        end else begin
            pend_r   <= (pend_r & ~clear_s) | set_s;
            itr_d_r  <= bus.itr_in;
            primed_r <= 1'b1;
        end
    end

    // Mask register, loaded on request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mask_r <= MASK_RST;
        end else if (bus.mask_we) begin
            mask_r <= bus.mask_in;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Winner id and vector are captured on entry to REQ and then frozen.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            int_id_r <= '0;
            pc_r     <= '0;
        end else if (load_s) begin
            int_id_r <= winner_s;
            pc_r     <= vector_of(winner_s);
        end else begin
            int_id_r <= int_id_r;
            pc_r     <= pc_r;
        end
    end

    assign bus.i_pending     = i_pending_r;
    assign bus.in_service    = in_service_r;
    assign bus.int_id        = int_id_r;
    assign bus.PC_out        = pc_r;
    assign bus.ITR_register  = pend_r;
    assign bus.MASK_register = mask_r;

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Scoreboard bench for vec_int_ctrl: a behavioural model predicts status and
// request vectors per clock; monitors compare what the DUT presents.
module tb_vec_int_ctrl;

    localparam logic [7:0] EDGE = 8'hEF;   // channel 4 is level-sensitive

    logic clk = 1'b0;
    logic clr = 1'b1;

    vec_int_if #(.NCH(8), .AW(8)) bus ();

    vec_int_ctrl #(.NCH(8), .AW(8), .EDGE_MODE(EDGE)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pend;
        logic [7:0] mask;
        logic       ip;
        logic       svc;
        logic [2:0] id;
        logic [7:0] pc;
    } stat_t;

    stat_t       stat_q[$];
    logic [10:0] req_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    // behavioural model state: mode 0 idle, 1 requesting, 2 servicing
    int         m_mode = 0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_mask = 8'hFF;
    logic [7:0] m_d    = 8'h00;
    bit         m_primed = 1'b0;
    int         m_id = 0;
    int         m_pc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] nxt;
        int         win;
        bit         rising;
        stat_t      s;
        logic [2:0] wid;
        logic [7:0] wpc;
        if (clr) begin
            m_mode = 0; m_pend = 8'h00; m_mask = 8'hFF; m_d = 8'h00;
            m_primed = 1'b0; m_id = 0; m_pc = 0;
        end else begin
            win = -1;
            for (int i = 7; i >= 0; i--) if (m_pend[i] && m_mask[i]) win = i;
            nxt = m_pend & ~bus.pend_clr;
            if (m_mode == 1 && bus.int_ack) nxt[m_id] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rising = bus.itr_in[i] && !m_d[i] && m_primed;
                if (EDGE[i] ? rising : bus.itr_in[i]) nxt[i] = 1'b1;
            end
            case (m_mode)
                0: if (bus.itr_en && win >= 0) begin
                       m_mode = 1;
                       m_id = win;
                       m_pc = (150 + 16 * win) % 256;
                       wid = 3'(win);
                       wpc = 8'(m_pc);
                       req_q.push_back({wid, wpc});
                   end
                1: if (bus.int_ack) m_mode = 2; else if (!bus.itr_en) m_mode = 0;
                2: if (bus.iret) m_mode = 0;
                default: m_mode = 0;
            endcase
            m_pend = nxt;
            if (bus.mask_we) m_mask = bus.mask_in;
            m_d = bus.itr_in;
            m_primed = 1'b1;
        end
        s.pend = m_pend; s.mask = m_mask;
        s.ip = (m_mode == 1); s.svc = (m_mode == 2);
        s.id = 3'(m_id); s.pc = 8'(m_pc);
        stat_q.push_back(s);
    endtask

    // model advances on every rising edge
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // status monitor: every cycle the DUT presents a status word
    initial begin : stat_mon
        stat_t e;
        logic  prev_ip;
        logic [10:0] r;
        prev_ip = 1'b0;
        forever begin
            @(negedge clk);
            if (stat_q.size() > 0) begin
                e = stat_q.pop_front();
                chk("ITR_register",  bus.ITR_register, e.pend);
                chk("MASK_register", bus.MASK_register, e.mask);
                chk("i_pending",     bus.i_pending, e.ip);
                chk("in_service",    bus.in_service, e.svc);
                chk("int_id",        bus.int_id, e.id);
                chk("PC_out",        bus.PC_out, e.pc);
            end
            if (bus.i_pending && !prev_ip) begin
                if (req_q.size() == 0) begin
                    chk("unexpected_request", 32'd1, 32'd0);
                end else begin
                    r = req_q.pop_front();
                    chk("req_id", bus.int_id, r[10:8]);
                    chk("req_vector", bus.PC_out, r[7:0]);
                end
            end
            prev_ip = bus.i_pending;
        end
    end

    // asynchronous reset monitor
    initial forever begin
        @(posedge clr);
        #1;
        chk("clr_i_pending",  bus.i_pending, 1'b0);
        chk("clr_in_service", bus.in_service, 1'b0);
        chk("clr_ITR",        bus.ITR_register, 8'h00);
        chk("clr_PC",         bus.PC_out, 8'h00);
        chk("clr_MASK",       bus.MASK_register, 8'hFF);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic service();
        bus.int_ack = 1'b1; cyc(); bus.int_ack = 1'b0;
        bus.iret = 1'b1; cyc(); bus.iret = 1'b0;
    endtask

    initial begin
        bus.itr_in = 8'h00; bus.itr_en = 1'b1; bus.mask_in = 8'h00;
        bus.mask_we = 1'b0; bus.pend_clr = 8'h00; bus.int_ack = 1'b0; bus.iret = 1'b0;
        cyc(); cyc();
        clr = 1'b0;
        cyc();
        chk("rst_MASK", bus.MASK_register, 8'hFF);
        chk("rst_ITR", bus.ITR_register, 8'h00);

        // channels 2 and 5 together
        bus.itr_in = 8'h24; cyc(); bus.itr_in = 8'h00; cyc();
        chk("t1_ip", bus.i_pending, 1'b1);
        chk("t1_id", bus.int_id, 3'd2);
        chk("t1_pc", bus.PC_out, 8'hB6);
        bus.int_ack = 1'b1; cyc(); bus.int_ack = 1'b0;
        chk("t1_svc", bus.in_service, 1'b1);
        chk("t1_itr", bus.ITR_register, 8'h20);
        bus.iret = 1'b1; cyc(); bus.iret = 1'b0;
        cyc();
        chk("t1_id5", bus.int_id, 3'd5);
        chk("t1_pc5", bus.PC_out, 8'hE6);
        service();

        // channel 7 vector wraps
        bus.itr_in = 8'h80; cyc(); bus.itr_in = 8'h00; cyc();
        chk("t2_pc_wrap", bus.PC_out, 8'h06);
        service();

        // masked channel latches but does not request
        bus.mask_we = 1'b1; bus.mask_in = 8'hFE; cyc();
        bus.mask_we = 1'b0; bus.itr_in = 8'h01; cyc();
        bus.itr_in = 8'h00; cyc();
        chk("t3_itr", bus.ITR_register, 8'h01);
        chk("t3_no_req", bus.i_pending, 1'b0);
        bus.mask_we = 1'b1; bus.mask_in = 8'hFF; cyc();
        bus.mask_we = 1'b0;
        chk("t3_still_idle", bus.i_pending, 1'b0);
        cyc();
        chk("t3_req", bus.i_pending, 1'b1);
        chk("t3_id0", bus.int_id, 3'd0);
        service();

        // frozen vector while a higher-priority channel arrives
        bus.itr_in = 8'h08; cyc(); bus.itr_in = 8'h00; cyc();
        chk("t4_pc3", bus.PC_out, 8'hC6);
        bus.itr_in = 8'h02; cyc(); bus.itr_in = 8'h00; cyc();
        chk("t4_frozen_id", bus.int_id, 3'd3);
        chk("t4_frozen_pc", bus.PC_out, 8'hC6);
        service();
        cyc();
        chk("t4_id1", bus.int_id, 3'd1);
        chk("t4_pc1", bus.PC_out, 8'hA6);
        service();

        // level channel 4 held through acknowledge
        bus.itr_in = 8'h10; cyc(); cyc();
        chk("t5_id4", bus.int_id, 3'd4);
        bus.int_ack = 1'b1; cyc(); bus.int_ack = 1'b0;
        chk("t5_level_sticky", bus.ITR_register, 8'h10);
        bus.iret = 1'b1; cyc(); bus.iret = 1'b0;
        cyc();
        chk("t5_rereq", bus.i_pending, 1'b1);
        chk("t5_rereq_id", bus.int_id, 3'd4);
        bus.itr_in = 8'h00;
        service();

        // reset mid-service; held edge lines do not re-pend
        bus.mask_we = 1'b1; bus.mask_in = 8'h0F; bus.itr_in = 8'h03; cyc();
        bus.mask_we = 1'b0; cyc();
        bus.int_ack = 1'b1; cyc(); bus.int_ack = 1'b0;
        chk("t6_svc", bus.in_service, 1'b1);
        chk("t6_itr", bus.ITR_register, 8'h02);
        clr = 1'b1;
        #1;
        chk("t6_mask_rst", bus.MASK_register, 8'hFF);
        chk("t6_svc_rst", bus.in_service, 1'b0);
        cyc(); clr = 1'b0; cyc(); cyc();
        chk("t6_no_repend", bus.ITR_register, 8'h00);
        chk("t6_no_req", bus.i_pending, 1'b0);
        bus.itr_in = 8'h00; cyc();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            bus.itr_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom() & $urandom()) : 8'h00;
            bus.itr_en   = ($urandom_range(0, 9) != 0);
            bus.mask_we  = ($urandom_range(0, 19) == 0);
            bus.mask_in  = 8'($urandom());
            bus.pend_clr = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'h00;
            bus.int_ack  = (m_mode == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            bus.iret     = (m_mode == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            clr          = ($urandom_range(0, 99) == 0);
            cyc();
        end
        clr = 1'b0;
        bus.itr_in = 8'h00; bus.int_ack = 1'b0; bus.iret = 1'b0;
        bus.mask_we = 1'b0; bus.pend_clr = 8'h00;
        cyc(); cyc();
        chk("req_q_drain", req_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_int_ctrl.md
# vec_int_ctrl

Parametrised, maskable, vectored priority interrupt controller with sticky pending latches, per-channel edge/level detection and an acknowledge/return handshake with the sequencer. It sits between the interrupt sources (ALU zero/overflow, illegal opcode, I/O and additional peripherals) and the control unit's PC-load path. It supplies a frozen ISR vector from request through acknowledge, and blocks further requests until the ISR returns.

## Interface
- NCH, 8: number of interrupt channels, 2..16; index 0 is highest priority.
- AW, 8: PC/vector width.
- IDW, $clog2(NCH): channel id width (derived).
- VEC_BASE, 8'h96: vector of channel 0.
- VEC_STRIDE, 8'h10: address step between consecutive channel vectors.
- EDGE_MODE, {NCH{1'b1}}: per channel, 1 = rising-edge detect, 0 = level.
- MASK_RST, {NCH{1'b1}}: mask register reset value; 1 = channel enabled.
- clk  in  1  system clock, all state updates on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- itr_in  in  NCH  raw interrupt source lines.
- itr_en  in  1  global interrupt enable.
- mask_in  in  NCH  new mask value.
- mask_we  in  1  load mask_in into mask register.
- pend_clr  in  NCH  write-1-to-clear pending bits.
- int_ack  in  1  sequencer accepts the presented vector.
- iret  in  1  ISR finished.
- i_pending  out  1  request to sequencer, vector valid.
- PC_out  out  AW  ISR vector address.
- int_id  out  IDW  channel being requested or serviced.
- in_service  out  1  ISR active.
- ITR_register  out  NCH  pending register.
- MASK_register  out  NCH  mask register.

## Operation
- Detection: itr_d holds the previous-cycle itr_in.
  - Edge channel: sets pend[i] when itr_in[i] & ~itr_d[i].
  - Level channel: sets pend[i] every cycle itr_in[i] is 1.
- Pending bits are sticky. They are cleared only by pend_clr, by ack of that channel, or by clr.
- Any set condition wins over a same-cycle clear (pend_clr or ack).
- Mask gates arbitration only. Masked channels still latch pending.
- mask_we takes effect at the next edge.
- Arbitration: req = pend & mask. The winner is the lowest index with req=1.
- Vector: PC_out = VEC_BASE + int_id*VEC_STRIDE, truncated to AW bits (modulo 2^AW wrap).
- IDLE:
  - When itr_en=1 and req≠0, go to REQ and latch winner into int_id and PC_out.
  - Otherwise stay.
- REQ: i_pending=1. int_id and PC_out are frozen and are not re-arbitrated, even if a higher-priority channel pends.
  - int_ack=1: go to SVC and clear pend[int_id].
  - itr_en=0 (without ack): go to IDLE with pend unchanged. int_ack wins if both occur.
  - If pend[int_id] is cleared by pend_clr while in REQ, the request stands until ack or itr_en drop.
- SVC: in_service=1, i_pending=0, int_id/PC_out held.
  - iret=1: go to IDLE.
  - No nesting: new requests are latched but not presented until return.
- Ignored inputs: int_ack outside REQ; iret outside SVC.
- Reset values:
  - state IDLE; pend, itr_d, int_id, PC_out all 0.
  - mask = MASK_RST; i_pending = in_service = 0.
- clr mid-operation aborts any REQ/SVC immediately (asynchronously) to IDLE.

## Timing
- Edge at clock k seen (itr_in=1, itr_d=0) → pend set at edge k → REQ entered at edge k+1 → i_pending high during cycle after k+1. Total latency: 2 edges from first sampled high.
- Ack sampled at edge m → in_service high and pend bit clear after m.
- iret at edge n → IDLE after n. If req≠0, REQ follows at n+1 (one idle cycle minimum between ISRs).
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
- Channels 2 and 5 pulse high one cycle together, mask=8'hFF, itr_en=1 → i_pending 2 cycles later, int_id=2, PC_out=8'hB6. After ack: ITR_register=8'h20. After iret: REQ with int_id=5, PC_out=8'hE6.
- Channel 7 request → PC_out=(8'h96+8'h70) mod 256 = 8'h06 (wrap check).
- mask=8'hFE, channel 0 pulses → ITR_register=8'h01, i_pending stays 0. mask_we to 8'hFF → i_pending next cycle after mask update + 1, int_id=0.
- In REQ for id 3, channel 1 pulses → vector stays 8'hC6 until ack. After iret, id 1 (PC_out=8'hA6) presented.
- Level channel 4 (EDGE_MODE bit 4=0) held high through ack → pend[4] remains 1. After iret, re-request id 4.
- clr asserted mid-SVC → in_service, i_pending, ITR_register, PC_out go 0 at once and MASK_register=MASK_RST. Edge channel held high across clr release does not re-pend.
